// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fetches NUM_OF_WORDS message words from word-addressed
// memory and streams the padded message (0x80000000 marker, zero fill, 64-bit
// bit length) as 16-word blocks over a valid/ready handshake.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic        w_last_blk,
  output logic        w_last_msg,
  output logic        done
);

  localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 18) / 16;
  localparam int          TOTAL      = 16 * NUM_BLOCKS;
  localparam logic [15:0] MSG_W      = 16'(NUM_OF_WORDS);
  localparam logic [15:0] TOTAL_W    = 16'(TOTAL);
  localparam logic [15:0] LAST_W     = 16'(TOTAL - 1);
  localparam logic [31:0] LEN_W      = 32'(NUM_OF_WORDS) << 5;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state;
  logic [15:0] base_addr;
  logic [15:0] iss_idx;
  logic [15:0] out_idx;
  // Issue stage: one word in flight (memory read or locally generated pad)
  logic        iss_vld_p0;
  logic        iss_mem_p0;
  logic [31:0] iss_pad_p0;
  // Prefetch buffer: up to two words waiting behind the output register
  logic [1:0]  buf_cnt;
  logic [31:0] buf0_p1;
  logic [31:0] buf1_p1;

  logic [31:0] in_word;
  logic [31:0] head_word;
  logic [31:0] e0;
  logic [31:0] e1;
  logic        head_ok;
  logic        load_out;
  logic        issue;
  logic [2:0]  occ_next;

  // Pad word for stream position idx once the message words are exhausted
  function automatic logic [31:0] pad_word(input logic [15:0] idx);
    if (idx == MSG_W)       return 32'h8000_0000;
    else if (idx == LAST_W) return LEN_W;
    else                    return 32'h0;
  endfunction

  assign mem_clk  = clk;
  assign mem_we   = 1'b0;
  assign mem_addr = base_addr + iss_idx;

  // The word landing this cycle either comes back from memory or was generated at issue
  assign in_word   = iss_mem_p0 ? mem_read_data : iss_pad_p0;
  assign head_ok   = (buf_cnt != 2'd0) || iss_vld_p0;
  assign head_word = (buf_cnt != 2'd0) ? buf0_p1 : in_word;
  assign load_out  = (!w_valid || w_ready) && head_ok;

  // Occupancy after this cycle's arrival and departure; a new issue must keep it at most 2
  assign occ_next = 3'(buf_cnt) + 3'(iss_vld_p0) - 3'(load_out);
  assign issue    = (state == FETCH) && (iss_idx < TOTAL_W) && (occ_next < 3'd2);

  // Ordered view of buffered words followed by the arriving word
  assign e0 = (buf_cnt != 2'd0) ? buf0_p1 : in_word;
  assign e1 = (buf_cnt == 2'd2) ? buf1_p1 : in_word;

  // Control: FSM, indices, occupancy and registered stream outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b1;
      base_addr  <= 16'h0;
      iss_idx    <= 16'h0;
      out_idx    <= 16'h0;
      iss_vld_p0 <= 1'b0;
      buf_cnt    <= 2'd0;
      w_valid    <= 1'b0;
      w_data     <= 32'h0;
      w_last_blk <= 1'b0;
      w_last_msg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            done      <= 1'b0;
            base_addr <= message_addr;
            iss_idx   <= 16'h0;
            out_idx   <= 16'h0;
          end
        end
        FETCH: begin
          if (issue && (iss_idx == LAST_W)) state <= DRAIN;
        end
        DRAIN: begin
          if (w_valid && w_ready && w_last_msg) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) iss_idx <= iss_idx + 16'd1;
      iss_vld_p0 <= issue;
      buf_cnt    <= occ_next[1:0];

      if (load_out) begin
        w_valid    <= 1'b1;
        w_data     <= head_word;
        w_last_blk <= (out_idx[3:0] == 4'hF);
        w_last_msg <= (out_idx == LAST_W);
        out_idx    <= out_idx + 16'd1;
      end else if (w_ready) begin
        w_valid <= 1'b0;
      end
    end
  end

  // Data: issue-stage word source and buffer contents (validity tracked by control)
  always_ff @(posedge clk) begin
    if (issue) begin
      iss_mem_p0 <= (iss_idx < MSG_W);
      iss_pad_p0 <= pad_word(iss_idx);
    end
    buf0_p1 <= load_out ? e1 : e0;
    buf1_p1 <= e1;
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: three instances (20, 13 and 14 message words)
// share one memory image; stream words are captured on handshakes and compared
// against a padded-message reference model.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] msg_addr = 16'h0100;
  logic [31:0] mem [0:4095];

  logic        start_a = 1'b0, w_ready_a = 1'b0;
  logic        mem_clk_a, mem_we_a, w_valid_a, lb_a, lm_a, done_a;
  logic [15:0] addr_a;
  logic [31:0] rd_a, w_data_a;

  logic        start_bc = 1'b0, ready_bc = 1'b0;
  logic        mem_clk_b, mem_we_b, w_valid_b, lb_b, lm_b, done_b;
  logic [15:0] addr_b;
  logic [31:0] rd_b, w_data_b;
  logic        mem_clk_c, mem_we_c, w_valid_c, lb_c, lm_c, done_c;
  logic [15:0] addr_c;
  logic [31:0] rd_c, w_data_c;

  typedef struct {
    logic [31:0] d;
    logic        lb;
    logic        lm;
    int          c;
  } wrec_t;

  wrec_t qa[$];
  wrec_t qb[$];
  wrec_t qc[$];
  int    qa_base = 0;
  int    qb_base = 0;
  int    qc_base = 0;
  int    stab_err = 0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_d = 32'h0;
  logic [1:0]  prev_f = 2'b00;

  sha256_msg_padder #(.NUM_OF_WORDS(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .message_addr(msg_addr),
    .mem_clk(mem_clk_a), .mem_we(mem_we_a), .mem_addr(addr_a), .mem_read_data(rd_a),
    .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
    .w_last_blk(lb_a), .w_last_msg(lm_a), .done(done_a));

  sha256_msg_padder #(.NUM_OF_WORDS(13)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_bc), .message_addr(msg_addr),
    .mem_clk(mem_clk_b), .mem_we(mem_we_b), .mem_addr(addr_b), .mem_read_data(rd_b),
    .w_valid(w_valid_b), .w_ready(ready_bc), .w_data(w_data_b),
    .w_last_blk(lb_b), .w_last_msg(lm_b), .done(done_b));

  sha256_msg_padder #(.NUM_OF_WORDS(14)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_bc), .message_addr(msg_addr),
    .mem_clk(mem_clk_c), .mem_we(mem_we_c), .mem_addr(addr_c), .mem_read_data(rd_c),
    .w_valid(w_valid_c), .w_ready(ready_bc), .w_data(w_data_c),
    .w_last_blk(lb_c), .w_last_msg(lm_c), .done(done_c));

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memory model, one cycle latency
  always @(posedge clk) begin
    rd_a <= mem[addr_a[11:0]];
    rd_b <= mem[addr_b[11:0]];
    rd_c <= mem[addr_c[11:0]];
  end

  // capture accepted words
  always @(negedge clk) begin
    if (reset_n && w_valid_a && w_ready_a) qa.push_back('{d: w_data_a, lb: lb_a, lm: lm_a, c: cyc});
    if (reset_n && w_valid_b && ready_bc)  qb.push_back('{d: w_data_b, lb: lb_b, lm: lm_b, c: cyc});
    if (reset_n && w_valid_c && ready_bc)  qc.push_back('{d: w_data_c, lb: lb_c, lm: lm_c, c: cyc});
  end

  // output must hold while stalled
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!w_valid_a || w_data_a !== prev_d || {lb_a, lm_a} !== prev_f))
        stab_err <= stab_err + 1;
      prev_stall <= w_valid_a && !w_ready_a;
      prev_d     <= w_data_a;
      prev_f     <= {lb_a, lm_a};
    end
  end

  function automatic logic [31:0] exp_word(input int nw, input int n);
    int tot;
    tot = 16 * ((nw + 18) / 16);
    if (n < nw)       return 32'(n + 1);
    if (n == nw)      return 32'h8000_0000;
    if (n == tot - 1) return 32'(nw * 32);
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_flags(input int nw, input int n);
    int tot;
    tot = 16 * ((nw + 18) / 16);
    return {(n % 16) == 15, n == tot - 1};
  endfunction

  task automatic drive_a(input bit rnd, input int start_at, output bit tmo,
                         output bit saw_busy, output int t0);
    bit sent;
    sent = 1'b0;
    tmo = 1'b1;
    saw_busy = 1'b0;
    qa_base = qa.size();
    @(posedge clk); #1;
    start_a = 1'b1;
    w_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 2000; k++) begin
      if (!done_a) saw_busy = 1'b1;
      if (done_a && saw_busy) begin
        tmo = 1'b0;
        break;
      end
      w_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_at >= 0 && !sent && (qa.size() - qa_base) >= start_at) begin
        start_a = 1'b1;
        sent = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (w_valid_a !== 1'b0) begin bad++; $display("FAIL rst_w_valid got=%b exp=0", w_valid_a); end
    total++; if (w_data_a !== 32'h0) begin bad++; $display("FAIL rst_w_data got=%h exp=0", w_data_a); end
    total++; if ({lb_a, lm_a} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {lb_a, lm_a}); end
    total++; if (addr_a !== 16'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", addr_a); end
    total++; if ({done_a, done_b, done_c} !== 3'b111) begin bad++; $display("FAIL rst_done got=%b exp=111", {done_a, done_b, done_c}); end
    total++; if ({mem_we_a, mem_we_b, mem_we_c} !== 3'b000) begin bad++; $display("FAIL mem_we got=%b exp=000", {mem_we_a, mem_we_b, mem_we_c}); end
    total++; if ({mem_clk_a, mem_clk_b, mem_clk_c} !== {3{clk}}) begin bad++; $display("FAIL mem_clk got=%b exp=%b", {mem_clk_a, mem_clk_b, mem_clk_c}, {3{clk}}); end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit tmo, busy;
    int t0, n;
    drive_a(1'b0, -1, tmo, busy, t0);
    n = qa.size() - qa_base;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", tmo); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_done_drop got=%b exp=1", busy); end
    total++; if (n !== 32) begin bad++; $display("FAIL basic_count got=%0d exp=32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      wrec_t r;
      r = qa[qa_base + i];
      total++; if (r.d !== exp_word(20, i)) begin bad++; $display("FAIL basic_w%0d got=%h exp=%h", i, r.d, exp_word(20, i)); end
      total++; if ({r.lb, r.lm} !== exp_flags(20, i)) begin bad++; $display("FAIL basic_flags%0d got=%b exp=%b", i, {r.lb, r.lm}, exp_flags(20, i)); end
    end
    if (n >= 1) begin
      total++; if ((qa[qa_base].c - t0) > 3) begin bad++; $display("FAIL basic_latency got=%0d exp<=3", qa[qa_base].c - t0); end
    end
    if (n >= 32) begin
      total++; if ((qa[qa_base + 31].c - qa[qa_base].c) !== 31) begin bad++; $display("FAIL basic_continuous got=%0d exp=31", qa[qa_base + 31].c - qa[qa_base].c); end
    end
    total++; if ({done_a, w_valid_a} !== 2'b10) begin bad++; $display("FAIL basic_end got=%b exp=10", {done_a, w_valid_a}); end
  endtask

  task automatic test_short_msgs();
    bit busy, fin;
    int nb, nc;
    qb_base = qb.size();
    qc_base = qc.size();
    busy = 1'b0;
    fin = 1'b0;
    @(posedge clk); #1;
    start_bc = 1'b1;
    ready_bc = 1'b1;
    @(posedge clk); #1;
    start_bc = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (!done_b || !done_c) busy = 1'b1;
      if (done_b && done_c && busy) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    nb = qb.size() - qb_base;
    nc = qc.size() - qc_base;
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL short_timeout got=%b exp=1", fin); end
    total++; if (nb !== 16) begin bad++; $display("FAIL n13_count got=%0d exp=16", nb); end
    total++; if (nc !== 32) begin bad++; $display("FAIL n14_count got=%0d exp=32", nc); end
    for (int i = 0; i < 16 && i < nb; i++) begin
      wrec_t r;
      r = qb[qb_base + i];
      total++; if (r.d !== exp_word(13, i)) begin bad++; $display("FAIL n13_w%0d got=%h exp=%h", i, r.d, exp_word(13, i)); end
      total++; if ({r.lb, r.lm} !== exp_flags(13, i)) begin bad++; $display("FAIL n13_flags%0d got=%b exp=%b", i, {r.lb, r.lm}, exp_flags(13, i)); end
    end
    for (int i = 0; i < 32 && i < nc; i++) begin
      wrec_t r;
      r = qc[qc_base + i];
      total++; if (r.d !== exp_word(14, i)) begin bad++; $display("FAIL n14_w%0d got=%h exp=%h", i, r.d, exp_word(14, i)); end
      total++; if ({r.lb, r.lm} !== exp_flags(14, i)) begin bad++; $display("FAIL n14_flags%0d got=%b exp=%b", i, {r.lb, r.lm}, exp_flags(14, i)); end
    end
    ready_bc = 1'b0;
  endtask

  task automatic test_random_ready();
    bit tmo, busy;
    int t0, n, se0;
    se0 = stab_err;
    drive_a(1'b1, -1, tmo, busy, t0);
    n = qa.size() - qa_base;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rnd_timeout got=%b exp=0", tmo); end
    total++; if (n !== 32) begin bad++; $display("FAIL rnd_count got=%0d exp=32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      wrec_t r;
      r = qa[qa_base + i];
      total++; if (r.d !== exp_word(20, i)) begin bad++; $display("FAIL rnd_w%0d got=%h exp=%h", i, r.d, exp_word(20, i)); end
      total++; if ({r.lb, r.lm} !== exp_flags(20, i)) begin bad++; $display("FAIL rnd_flags%0d got=%b exp=%b", i, {r.lb, r.lm}, exp_flags(20, i)); end
    end
    total++; if ((stab_err - se0) !== 0) begin bad++; $display("FAIL rnd_stall_stable got=%0d exp=0", stab_err - se0); end
  endtask

  task automatic test_start_ignored();
    bit tmo, busy;
    int t0, n;
    drive_a(1'b0, 10, tmo, busy, t0);
    n = qa.size() - qa_base;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL busy_start_timeout got=%b exp=0", tmo); end
    total++; if (n !== 32) begin bad++; $display("FAIL busy_start_count got=%0d exp=32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      wrec_t r;
      r = qa[qa_base + i];
      total++; if (r.d !== exp_word(20, i)) begin bad++; $display("FAIL busy_start_w%0d got=%h exp=%h", i, r.d, exp_word(20, i)); end
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if ({done_a, w_valid_a} !== 2'b10) begin bad++; $display("FAIL busy_start_idle got=%b exp=10", {done_a, w_valid_a}); end
  endtask

  task automatic test_reset_mid();
    bit tmo, busy, hit;
    int t0, n, n7;
    qa_base = qa.size();
    hit = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b1;
    w_ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ((qa.size() - qa_base) >= 7) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_reach7 got=%b exp=1", hit); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (w_valid_a !== 1'b0) begin bad++; $display("FAIL rstmid_w_valid got=%b exp=0", w_valid_a); end
    total++; if (w_data_a !== 32'h0) begin bad++; $display("FAIL rstmid_w_data got=%h exp=0", w_data_a); end
    total++; if ({lb_a, lm_a, done_a} !== 3'b001) begin bad++; $display("FAIL rstmid_flags_done got=%b exp=001", {lb_a, lm_a, done_a}); end
    total++; if (addr_a !== 16'h0) begin bad++; $display("FAIL rstmid_mem_addr got=%h exp=0", addr_a); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n7 = qa.size() - qa_base;
    total++; if (n7 !== 7) begin bad++; $display("FAIL rstmid_abort got=%0d exp=7", n7); end
    total++; if ({done_a, w_valid_a} !== 2'b10) begin bad++; $display("FAIL rstmid_idle got=%b exp=10", {done_a, w_valid_a}); end
    drive_a(1'b0, -1, tmo, busy, t0);
    n = qa.size() - qa_base;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL replay_timeout got=%b exp=0", tmo); end
    total++; if (n !== 32) begin bad++; $display("FAIL replay_count got=%0d exp=32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      wrec_t r;
      r = qa[qa_base + i];
      total++; if (r.d !== exp_word(20, i)) begin bad++; $display("FAIL replay_w%0d got=%h exp=%h", i, r.d, exp_word(20, i)); end
      total++; if ({r.lb, r.lm} !== exp_flags(20, i)) begin bad++; $display("FAIL replay_flags%0d got=%b exp=%b", i, {r.lb, r.lm}, exp_flags(20, i)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 32'(i + 1);
    test_reset();
    test_basic();
    test_short_msgs();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
